// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the data load/store unit.
// Holds the FSM state encoding, access-size codes, the byte-enable mask
// function and the misalignment check.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        WAIT1 = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        RESP  = 3'd5
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Unshifted byte-enable pattern for an access size; the illegal size gives no lanes.
    function automatic logic [3:0] be_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SIZE_B:  m = 4'b0001;
            SIZE_H:  m = 4'b0011;
            SIZE_W:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // An access is misaligned when it would cross a word boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_H) && (off == 2'd3)) ||
               ((size == SIZE_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment for the load/store unit.
// Shifts store data into its byte lanes, shifts (and, with
// LSU_MISALIGN_SPLIT_EN, merges two words of) load data down to bit 0,
// then sign- or zero-extends it to 32 bits by access size.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
`ifdef LSU_MISALIGN_SPLIT_EN
    input  logic [31:0] rdata_hi,
    output logic [31:0] wdata_hi,
`endif
    output logic [31:0] wdata_lo,
    output logic [31:0] rdata_ext
);

    logic [4:0]         sh;
    logic [31:0]        merged;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign sh = {off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    // Shift amount for the part that spills into the following word; 32 yields zero.
    logic [5:0] sh_inv;
    assign sh_inv   = 6'd32 - {1'b0, sh};
    assign wdata_hi = wdata >> sh_inv;
    assign merged   = (rdata_lo >> sh) | (rdata_hi << sh_inv);
`else
    assign merged   = rdata_lo >> sh;
`endif

    assign wdata_lo = wdata << sh;
    assign byte_s   = merged[7:0];
    assign half_s   = merged[15:0];

    // Extend the right-aligned load data above the access size.
    always_comb begin
        rdata_ext = merged;
        case (size)
            SIZE_B:  rdata_ext = is_unsigned ? {24'd0, merged[7:0]}  : 32'(byte_s);
            SIZE_H:  rdata_ext = is_unsigned ? {16'd0, merged[15:0]} : 32'(half_s);
            default: rdata_ext = merged;
        endcase
    end

endmodule

// File: rtl/data_lsu.sv
// data_lsu: load/store unit between the core data port and data memory.
// One access outstanding at a time; illegal sizes and misaligned accesses
// return an error response without touching memory. Defining
// LSU_MISALIGN_SPLIT_EN instead splits misaligned accesses into two
// aligned memory transactions (REQ2/WAIT2).
module data_lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        res_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic        core_unsigned,
    input  logic [31:0] core_adr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic        data_req,
    output logic [31:0] data_adr,
    output logic        data_we,
    output logic [3:0]  data_be,
    output logic [31:0] data_wdata,
    input  logic        data_gnt,
    input  logic        data_rvalid,
    input  logic [31:0] data_rdata
);

    lsu_state_t  state, state_next;

    logic [31:0] adr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_lo_q;

    logic        access_bad;
    logic [31:0] adr_lo;
    logic [3:0]  be_lo;
    logic [31:0] wdata_lo;
    logic [31:0] rdata_ext;

    assign core_gnt = core_req & (state == IDLE);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] rdata_hi_q;
    logic [3:0]  be_hi;
    logic [31:0] wdata_hi;

    assign access_bad = (core_size == 2'b11);
    assign be_hi      = be_mask(size_q) >> (3'd4 - {1'b0, adr_q[1:0]});
`else
    assign access_bad = (core_size == 2'b11) || misaligned(core_size, core_adr[1:0]);
`endif

    assign adr_lo = {adr_q[31:2], 2'b00};
    assign be_lo  = be_mask(size_q) << adr_q[1:0];

    lsu_align u_align (
        .off         (adr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata_lo    (rdata_lo_q),
`ifdef LSU_MISALIGN_SPLIT_EN
        .rdata_hi    (rdata_hi_q),
        .wdata_hi    (wdata_hi),
`endif
        .wdata_lo    (wdata_lo),
        .rdata_ext   (rdata_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else        state <= state_next;
    end

    // Capture the access on grant and the memory words as they return.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            adr_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_lo_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            rdata_hi_q <= '0;
`endif
        end else begin
            if (core_gnt) begin
                adr_q      <= core_adr;
                we_q       <= core_we;
                size_q     <= core_size;
                uns_q      <= core_unsigned;
                wdata_q    <= core_wdata;
                err_q      <= access_bad;
                rdata_lo_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                rdata_hi_q <= '0;
`endif
            end
            if ((state == WAIT1) && data_rvalid) rdata_lo_q <= data_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            if ((state == WAIT2) && data_rvalid) rdata_hi_q <= data_rdata;
`endif
        end
    end

    // Next-state logic and all handshake outputs; memory signals are zero outside REQ states.
    always_comb begin
        state_next  = state;
        data_req    = 1'b0;
        data_adr    = '0;
        data_we     = 1'b0;
        data_be     = '0;
        data_wdata  = '0;
        core_rvalid = 1'b0;
        core_err    = 1'b0;
        core_rdata  = '0;
        case (state)
            IDLE: begin
                if (core_req) state_next = access_bad ? RESP : REQ1;
            end
            REQ1: begin
                data_req   = 1'b1;
                data_adr   = adr_lo;
                data_we    = we_q;
                data_be    = be_lo;
                data_wdata = wdata_lo;
                if (data_gnt) state_next = WAIT1;
            end
            WAIT1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (data_rvalid) state_next = misaligned(size_q, adr_q[1:0]) ? REQ2 : RESP;
`else
                if (data_rvalid) state_next = RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ2: begin
                data_req   = 1'b1;
                data_adr   = adr_lo + 32'd4;
                data_we    = we_q;
                data_be    = be_hi;
                data_wdata = wdata_hi;
                if (data_gnt) state_next = WAIT2;
            end
            WAIT2: begin
                if (data_rvalid) state_next = RESP;
            end
`endif
            RESP: begin
                core_rvalid = 1'b1;
                core_err    = err_q;
                core_rdata  = (err_q || we_q) ? 32'd0 : rdata_ext;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_lsu.sv
// tb_data_lsu: directed self-checking bench for data_lsu.
module tb_data_lsu;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [1:0]  core_size = 2'b00;
    logic        core_unsigned = 1'b0;
    logic [31:0] core_adr = '0;
    logic [31:0] core_wdata = '0;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        data_req;
    logic [31:0] data_adr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt = 1'b0;
    logic        data_rvalid = 1'b0;
    logic [31:0] data_rdata = '0;

    int total = 0;
    int bad = 0;

    // Observations of the most recent access.
    logic        gnt0;
    int          nreq;
    int          lat;
    logic [31:0] rd_out;
    logic        err_out;
    logic        stable;
    logic [31:0] rq_adr [2];
    logic [3:0]  rq_be  [2];
    logic [31:0] rq_wd  [2];
    logic        rq_we  [2];

    data_lsu dut (
        .clk           (clk),
        .res_n         (res_n),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_size     (core_size),
        .core_unsigned (core_unsigned),
        .core_adr      (core_adr),
        .core_wdata    (core_wdata),
        .core_gnt      (core_gnt),
        .core_rvalid   (core_rvalid),
        .core_rdata    (core_rdata),
        .core_err      (core_err),
        .data_req      (data_req),
        .data_adr      (data_adr),
        .data_we       (data_we),
        .data_be       (data_be),
        .data_wdata    (data_wdata),
        .data_gnt      (data_gnt),
        .data_rvalid   (data_rvalid),
        .data_rdata    (data_rdata)
    );

    always #5 clk = ~clk;

    // Drive one access from a negedge, playing memory with gw extra gnt cycles
    // and rw extra rvalid cycles; cycle 0 is the grant cycle.
    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] adr, input logic [31:0] wd,
                             input int gw, input int rw,
                             input logic [31:0] rd1, input logic [31:0] rd2);
        int wait_g = 0;
        int rv_cnt = -1;
        int resp_idx = 0;
        bit done = 0;
        gnt0 = 0; nreq = 0; lat = -1; rd_out = '0; err_out = 0; stable = 1;
        for (int i = 0; i < 2; i++) begin
            rq_adr[i] = '0; rq_be[i] = '0; rq_wd[i] = '0; rq_we[i] = 0;
        end
        core_req = 1; core_we = we; core_size = size; core_unsigned = uns;
        core_adr = adr; core_wdata = wd;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            data_gnt = 0; data_rvalid = 0; data_rdata = '0;
            if (cyc == 0) gnt0 = core_gnt;
            if (core_rvalid) begin
                lat = cyc; rd_out = core_rdata; err_out = core_err; done = 1;
            end
            if (rv_cnt == 0) begin
                data_rvalid = 1;
                data_rdata = (resp_idx == 0) ? rd1 : rd2;
                resp_idx++;
                rv_cnt = -1;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
            end
            if (data_req) begin
                if (wait_g == 0) begin
                    if (nreq < 2) begin
                        rq_adr[nreq] = data_adr; rq_be[nreq] = data_be;
                        rq_wd[nreq] = data_wdata; rq_we[nreq] = data_we;
                    end
                    nreq++;
                end else if (nreq <= 2) begin
                    if (data_adr !== rq_adr[nreq-1] || data_be !== rq_be[nreq-1] ||
                        data_wdata !== rq_wd[nreq-1]) stable = 0;
                end
                if (wait_g == gw) begin
                    data_gnt = 1; wait_g = 0; rv_cnt = rw;
                end else begin
                    wait_g++;
                end
            end
            @(negedge clk);
            if (cyc == 0) core_req = 0;
        end
        data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    endtask

    task automatic test_reset;
        #1;
        total++; if ({core_gnt, core_rvalid, core_err} !== 3'b000) begin
            bad++; $display("FAIL reset_core_ctl got=%b want=000", {core_gnt, core_rvalid, core_err}); end
        total++; if (core_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_core_rdata got=%h want=0", core_rdata); end
        total++; if ({data_req, data_we, data_be} !== 6'd0) begin
            bad++; $display("FAIL reset_data_ctl got=%b want=000000", {data_req, data_we, data_be}); end
        total++; if (data_adr !== 32'd0 || data_wdata !== 32'd0) begin
            bad++; $display("FAIL reset_data_bus got=%h/%h want=0/0", data_adr, data_wdata); end
        @(negedge clk);
    endtask

    task automatic test_word_store;
        do_access(1'b1, 2'b10, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'd0);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL sw_gnt got=%b want=1", gnt0); end
        total++; if (nreq !== 1) begin bad++; $display("FAIL sw_nreq got=%0d want=1", nreq); end
        total++; if (rq_adr[0] !== 32'h1000_0008) begin
            bad++; $display("FAIL sw_adr got=%h want=10000008", rq_adr[0]); end
        total++; if (rq_be[0] !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b want=1111", rq_be[0]); end
        total++; if (rq_wd[0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL sw_wdata got=%h want=deadbeef", rq_wd[0]); end
        total++; if (rq_we[0] !== 1'b1) begin bad++; $display("FAIL sw_we got=%b want=1", rq_we[0]); end
        total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d want=3", lat); end
        total++; if (err_out !== 1'b0 || rd_out !== 32'd0) begin
            bad++; $display("FAIL sw_resp got=%b/%h want=0/0", err_out, rd_out); end
    endtask

    task automatic test_byte_load;
        do_access(1'b0, 2'b00, 1'b0, 32'h2000_0003, 32'd0, 0, 0, 32'h80FF_FFFF, 32'd0);
        total++; if (rq_adr[0] !== 32'h2000_0000) begin
            bad++; $display("FAIL lb_adr got=%h want=20000000", rq_adr[0]); end
        total++; if (rq_be[0] !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b want=1000", rq_be[0]); end
        total++; if (rq_we[0] !== 1'b0) begin bad++; $display("FAIL lb_we got=%b want=0", rq_we[0]); end
        total++; if (rd_out !== 32'hFFFF_FF80) begin
            bad++; $display("FAIL lb_signed got=%h want=ffffff80", rd_out); end
        do_access(1'b0, 2'b00, 1'b1, 32'h2000_0003, 32'd0, 0, 0, 32'h80FF_FFFF, 32'd0);
        total++; if (rd_out !== 32'h0000_0080) begin
            bad++; $display("FAIL lbu_unsigned got=%h want=00000080", rd_out); end
        total++; if (lat !== 3) begin bad++; $display("FAIL lbu_latency got=%0d want=3", lat); end
    endtask

    task automatic test_half_wait;
        do_access(1'b0, 2'b01, 1'b0, 32'h3000_0006, 32'd0, 3, 2, 32'h8765_1234, 32'd0);
        total++; if (rq_adr[0] !== 32'h3000_0004) begin
            bad++; $display("FAIL lh_adr got=%h want=30000004", rq_adr[0]); end
        total++; if (rq_be[0] !== 4'b1100) begin bad++; $display("FAIL lh_be got=%b want=1100", rq_be[0]); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL lh_stable got=%b want=1", stable); end
        total++; if (nreq !== 1) begin bad++; $display("FAIL lh_nreq got=%0d want=1", nreq); end
        total++; if (rd_out !== 32'hFFFF_8765) begin
            bad++; $display("FAIL lh_rdata got=%h want=ffff8765", rd_out); end
        total++; if (lat !== 8) begin bad++; $display("FAIL lh_latency got=%0d want=8", lat); end
    endtask

    task automatic test_half_store_lanes;
        do_access(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h1234_ABCD, 0, 0, 32'd0, 32'd0);
        total++; if (rq_be[0] !== 4'b0110) begin bad++; $display("FAIL sh_be got=%b want=0110", rq_be[0]); end
        total++; if (rq_wd[0] !== 32'h34AB_CD00) begin
            bad++; $display("FAIL sh_wdata got=%h want=34abcd00", rq_wd[0]); end
        total++; if (rq_adr[0] !== 32'h0000_0100) begin
            bad++; $display("FAIL sh_adr got=%h want=00000100", rq_adr[0]); end
        do_access(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'd0, 1, 0, 32'h9ABC_0000, 32'd0);
        total++; if (rd_out !== 32'h0000_9ABC) begin
            bad++; $display("FAIL lhu_rdata got=%h want=00009abc", rd_out); end
        total++; if (lat !== 4) begin bad++; $display("FAIL lhu_latency got=%0d want=4", lat); end
    endtask

    task automatic test_illegal;
        do_access(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'd0, 0, 0, 32'hFFFF_FFFF, 32'd0);
        total++; if (nreq !== 0) begin bad++; $display("FAIL ill_nreq got=%0d want=0", nreq); end
        total++; if (lat !== 1) begin bad++; $display("FAIL ill_latency got=%0d want=1", lat); end
        total++; if (err_out !== 1'b1 || rd_out !== 32'd0) begin
            bad++; $display("FAIL ill_resp got=%b/%h want=1/0", err_out, rd_out); end
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    task automatic test_misaligned;
        do_access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'd0, 0, 0, 32'hAABB_1111, 32'h2222_CCDD);
        total++; if (nreq !== 2) begin bad++; $display("FAIL spl_nreq got=%0d want=2", nreq); end
        total++; if (rq_adr[0] !== 32'hFFFF_FFFC || rq_be[0] !== 4'b1100) begin
            bad++; $display("FAIL spl_req1 got=%h/%b want=fffffffc/1100", rq_adr[0], rq_be[0]); end
        total++; if (rq_adr[1] !== 32'h0000_0000 || rq_be[1] !== 4'b0011) begin
            bad++; $display("FAIL spl_req2 got=%h/%b want=00000000/0011", rq_adr[1], rq_be[1]); end
        total++; if (rd_out !== 32'hCCDD_AABB || err_out !== 1'b0) begin
            bad++; $display("FAIL spl_rdata got=%h/%b want=ccddaabb/0", rd_out, err_out); end
        total++; if (lat !== 5) begin bad++; $display("FAIL spl_latency got=%0d want=5", lat); end
    endtask
`else
    task automatic test_misaligned;
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_0021, 32'd0, 0, 0, 32'h5555_5555, 32'd0);
        total++; if (nreq !== 0) begin bad++; $display("FAIL mis_nreq got=%0d want=0", nreq); end
        total++; if (lat !== 1) begin bad++; $display("FAIL mis_latency got=%0d want=1", lat); end
        total++; if (err_out !== 1'b1 || rd_out !== 32'd0) begin
            bad++; $display("FAIL mis_resp got=%b/%h want=1/0", err_out, rd_out); end
    endtask
`endif

    task automatic test_back_to_back;
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'd0, 0, 0, 32'h0102_0304, 32'd0);
        do_access(1'b0, 2'b00, 1'b0, 32'h0000_0045, 32'd0, 0, 0, 32'h0000_7F00, 32'd0);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL b2b_gnt got=%b want=1", gnt0); end
        total++; if (rd_out !== 32'h0000_007F) begin
            bad++; $display("FAIL b2b_rdata got=%h want=0000007f", rd_out); end
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency got=%0d want=3", lat); end
    endtask

    task automatic test_reset_mid;
        core_req = 1; core_we = 0; core_size = 2'b10; core_unsigned = 0;
        core_adr = 32'h4000_0000; core_wdata = '0;
        @(negedge clk);
        core_req = 0;
        #1;
        total++; if (data_req !== 1'b1) begin bad++; $display("FAIL rm_req got=%b want=1", data_req); end
        data_gnt = 1;
        @(negedge clk);
        data_gnt = 0;
        res_n = 0;
        #1;
        total++; if ({core_rvalid, core_err, data_req, data_we, data_be} !== 8'd0 ||
                     data_adr !== 32'd0 || core_rdata !== 32'd0 || data_wdata !== 32'd0) begin
            bad++; $display("FAIL rm_outputs got=%b/%h want=0/0",
                            {core_rvalid, core_err, data_req, data_we, data_be}, data_adr); end
        @(negedge clk);
        res_n = 1;
        data_rvalid = 1; data_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        data_rvalid = 0; data_rdata = '0;
        #1;
        total++; if (core_rvalid !== 1'b0 || data_req !== 1'b0) begin
            bad++; $display("FAIL rm_ignored got=%b/%b want=0/0", core_rvalid, data_req); end
        @(negedge clk);
        do_access(1'b0, 2'b10, 1'b0, 32'h4000_0010, 32'd0, 0, 0, 32'h1234_5678, 32'd0);
        total++; if (rd_out !== 32'h1234_5678 || lat !== 3) begin
            bad++; $display("FAIL rm_after got=%h/%0d want=12345678/3", rd_out, lat); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        res_n = 1;
        @(negedge clk);
        test_word_store();
        test_byte_load();
        test_half_wait();
        test_half_store_lanes();
        test_illegal();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
